fmap_streamer: RTL

Frame-level source of the 1-bit serial pixel stream consumed by the `window` line buffer in the BNN accelerator. Reads a binary feature map one packed row word at a time from an external row memory and serializes it in raster order, MSB first. Drives the `start`/`din` pair that the line buffer shifts on. Supports the two frame sizes selected by `state`: 28×28 and 12×12. Within a frame the stream is gapless unless the consumer asserts `hold`.

---
 rtl/bnn_stream_pkg.sv | 28 ++
 rtl/fmap_streamer_row_serializer.sv | 52 +++++
 rtl/fmap_streamer.sv | 126 ++++++++++++
 3 files changed

// File: rtl/bnn_stream_pkg.sv
// Shared constants, FSM encoding and window tap offsets for the BNN pixel stream.
package bnn_stream_pkg;

  localparam int FW_L = 28;   // large frame width/height
  localparam int FW_S = 12;   // small frame width/height
  localparam int RW   = 28;   // row word width (largest frame width)
  localparam int AW   = 5;    // row address / coordinate width

  // Line-buffer tap offsets used by the window block, one and two rows back
  localparam int TAP1_L = FW_L;
  localparam int TAP2_L = 2 * FW_L;
  localparam int TAP1_S = FW_S;
  localparam int TAP2_S = 2 * FW_S;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    STREAM,
    DONE
  } strm_state_t;

  // Index of the last row/column for the selected frame size
  function automatic logic [AW-1:0] last_idx(input logic mode);
    return mode ? AW'(FW_S - 1) : AW'(FW_L - 1);
  endfunction

endpackage

// File: rtl/fmap_streamer_row_serializer.sv
// Holds the active row word and the prefetched next row; presents the MSB as the pixel.
module row_serializer
  import bnn_stream_pkg::*;
#(
  parameter int W = RW
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,      // capture first row of the frame
  input  logic         shift,     // advance to the next column
  input  logic         swap,      // row boundary: take the prefetched row
  input  logic         prefetch,  // read for the next row issued this cycle
  input  logic [W-1:0] rd_data,
  output logic         din
);

  logic [W-1:0] sreg_q, sreg_d;
  logic [W-1:0] nxt_q, nxt_d;
  logic         pf_q;

  // Next-state of the shift register and prefetch buffer
  always_comb begin
    sreg_d = sreg_q;
    nxt_d  = nxt_q;
    if (pf_q) begin
      nxt_d = rd_data;            // memory answers one cycle after the strobe
    end
    if (load) begin
      sreg_d = rd_data;
    end else if (swap) begin
      sreg_d = nxt_q;
    end else if (shift) begin
      sreg_d = {sreg_q[W-2:0], 1'b0};
    end
  end

  // Register update with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      sreg_q <= '0;
      nxt_q  <= '0;
      pf_q   <= 1'b0;
    end else begin
      sreg_q <= sreg_d;
      nxt_q  <= nxt_d;
      pf_q   <= prefetch;
    end
  end

  assign din = sreg_q[W-1];

endmodule

// File: rtl/fmap_streamer.sv
// Frame source: fetches packed feature-map rows and serializes them MSB first in raster order.
module fmap_streamer
  import bnn_stream_pkg::*;
#(
  parameter int RW = bnn_stream_pkg::RW,
  parameter int AW = bnn_stream_pkg::AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          go,
  input  logic          state,
  input  logic          hold,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [RW-1:0] rd_data,
  output logic          start,
  output logic          din,
  output logic [AW-1:0] row,
  output logic [AW-1:0] col,
  output logic          busy,
  output logic          done
);

  strm_state_t   state_q, state_d;
  logic          mode_q, mode_d;
  logic [AW-1:0] row_q, row_d;
  logic [AW-1:0] col_q, col_d;
  logic [AW-1:0] wlast;
  logic          load, shift, swap, prefetch;

  assign wlast = last_idx(mode_q);

  // Next-state, counters and all combinational outputs
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    row_d    = row_q;
    col_d    = col_q;
    start    = 1'b0;
    rd_en    = 1'b0;
    rd_addr  = '0;
    busy     = 1'b0;
    done     = 1'b0;
    load     = 1'b0;
    shift    = 1'b0;
    swap     = 1'b0;
    prefetch = 1'b0;
    case (state_q)
      IDLE: begin
        if (go) begin
          mode_d  = state;
          row_d   = '0;
          col_d   = '0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        busy    = 1'b1;
        rd_en   = 1'b1;
        state_d = LOAD;
      end
      LOAD: begin
        busy    = 1'b1;
        load    = 1'b1;
        state_d = STREAM;
      end
      STREAM: begin
        busy  = 1'b1;
        start = !hold;
        if (start) begin
          // First column of a row (not the last row): fetch the following row
          if (col_q == '0 && row_q < wlast) begin
            rd_en    = 1'b1;
            rd_addr  = row_q + AW'(1);
            prefetch = 1'b1;
          end
          if (col_q < wlast) begin
            shift = 1'b1;
            col_d = col_q + AW'(1);
          end else if (row_q < wlast) begin
            swap  = 1'b1;
            col_d = '0;
            row_d = row_q + AW'(1);
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, mode and coordinate registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  assign row = row_q;
  assign col = col_q;

  row_serializer #(.W(RW)) u_ser (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .shift    (shift),
    .swap     (swap),
    .prefetch (prefetch),
    .rd_data  (rd_data),
    .din      (din)
  );

endmodule
